// File: rtl/instr_loader_if.sv
// Host-side byte stream, load control and instruction-buffer write port of the loader.
`timescale 1ns/1ps
interface instr_loader_if #(parameter int unsigned ADDR_W = 10);
   logic              start;
   logic [0:ADDR_W-1] start_addr;
   logic [0:ADDR_W]   word_count;
   logic              abort;
   logic              byte_valid;
   logic [0:7]        byte_in;
   logic              byte_ready;
   logic              load_en;
   logic [0:ADDR_W-1] instr_load_addr;
   logic [0:31]       instruction_in;
   logic              busy;
   logic              core_hold;
   logic              done;
   logic              error;

   modport master (
      output start, start_addr, word_count, abort, byte_valid, byte_in,
      input  byte_ready, load_en, instr_load_addr, instruction_in,
             busy, core_hold, done, error
   );

   modport slave (
      input  start, start_addr, word_count, abort, byte_valid, byte_in,
      output byte_ready, load_en, instr_load_addr, instruction_in,
             busy, core_hold, done, error
   );
endinterface

// File: rtl/instr_loader.sv
// Program loader: assembles big-endian words from a byte stream and writes them
// into consecutive instruction-buffer locations while holding the fetch core.
`timescale 1ns/1ps
module instr_loader #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input logic           clk,
   input logic           rst,
   instr_loader_if.slave bus
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned SUM_W = ADDR_W + 2;

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t            state;
   logic [1:0]        byte_cnt;
   logic [0:23]       asm_q;
   logic [0:ADDR_W-1] addr_q;
   logic [0:CNT_W-1]  remaining;

   logic              byte_ready_q;
   logic              load_en_q;
   logic [0:ADDR_W-1] load_addr_q;
   logic [0:31]       instr_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;

   logic [0:SUM_W-1]  end_addr_c;
   logic              reject_c;

   // Extra headroom bit keeps the end-address check from wrapping.
   assign end_addr_c = SUM_W'(bus.start_addr) + SUM_W'(bus.word_count);
   assign reject_c   = (bus.word_count == '0) ||
                       (bus.word_count > CNT_W'(DEPTH)) ||
                       (end_addr_c > SUM_W'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         asm_q        <= '0;
         addr_q       <= '0;
         remaining    <= '0;
         byte_ready_q <= 1'b0;
         load_en_q    <= 1'b0;
         load_addr_q  <= '0;
         instr_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         load_en_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  done_q <= 1'b0;
                  if (reject_c) begin
                     error_q <= 1'b1;
                  end else begin
                     error_q      <= 1'b0;
                     addr_q       <= bus.start_addr;
                     remaining    <= bus.word_count;
                     byte_cnt     <= '0;
                     busy_q       <= 1'b1;
                     byte_ready_q <= 1'b1;
                     state        <= RECV;
                  end
               end
            end
            RECV: begin
               if (bus.abort) begin
                  byte_cnt     <= '0;
                  busy_q       <= 1'b0;
                  byte_ready_q <= 1'b0;
                  done_q       <= 1'b0;
                  error_q      <= 1'b0;
                  state        <= IDLE;
               end else if (bus.byte_valid && byte_ready_q) begin
                  if (byte_cnt == 2'd3) begin
                     // Fourth byte completes the word; present it on the write port.
                     instr_q      <= {asm_q, bus.byte_in};
                     load_addr_q  <= addr_q;
                     load_en_q    <= 1'b1;
                     byte_ready_q <= 1'b0;
                     byte_cnt     <= '0;
                     state        <= WRITE;
                  end else begin
                     asm_q    <= {asm_q[8:23], bus.byte_in};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            WRITE: begin
               addr_q    <= addr_q + ADDR_W'(1);
               remaining <= remaining - CNT_W'(1);
               if (bus.abort) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  state   <= IDLE;
               end else if (remaining == CNT_W'(1)) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  byte_ready_q <= 1'b1;
                  state        <= RECV;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready      = byte_ready_q;
   assign bus.load_en         = load_en_q;
   assign bus.instr_load_addr = load_addr_q;
   assign bus.instruction_in  = instr_q;
   assign bus.busy            = busy_q;
   assign bus.core_hold       = busy_q;
   assign bus.done            = done_q;
   assign bus.error           = error_q;
endmodule
